// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the simple-dual-port scratch RAM.
// Consumed by sync_ram_2p through a package import.
package sync_ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int calc_data_w(input int lane_w, input int num_lanes);
    return lane_w * num_lanes;
  endfunction

endpackage

// File: rtl/ram_lane.sv
// One LANE_W-wide storage lane: clocked write, combinational read of the array.
// The array is deliberately not reset; the top-level clear sequencer zeroes it.
module ram_lane #(
  parameter int LANE_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [LANE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [LANE_W-1:0] rdata_o
);

  logic [LANE_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_ram_2p.sv
// Simple-dual-port RAM with byte-lane writes, write-first bypass and a 1-cycle registered read.
// A clear sequencer zeroes every word after reset or on clear_req; requests are dropped while init_busy.
module sync_ram_2p
  import sync_ram_pkg::*;
#(
  parameter int LANE_W         = 8,
  parameter int NUM_LANES      = 1,
  parameter int ADDR_W         = 4,
  parameter int CLEAR_ON_RESET = 1,
  localparam int DATA_W        = calc_data_w(LANE_W, NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [NUM_LANES-1:0] wr_be,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 clear_req,
  output logic                 init_busy
);

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? INIT : READY;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [NUM_LANES-1:0]  lane_we;
  logic [ADDR_W-1:0]     lane_waddr;
  logic [DATA_W-1:0]     lane_wdata;
  logic [DATA_W-1:0]     rd_word;
  logic                  bypass_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      clr_ptr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // The last clear step is decoded from the pointer value, not from its wrap.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      INIT: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == {ADDR_W{1'b1}}) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clear_req) begin
          state_d   = INIT;
          clr_ptr_d = '0;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    init_busy  = (state_q == INIT);
    lane_we    = '0;
    lane_waddr = wr_addr;
    lane_wdata = wr_data;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (state_q == INIT) begin
      lane_we    = '1;
      lane_waddr = clr_ptr_q;
      lane_wdata = '0;
    end else begin
      lane_we = wr_en ? wr_be : '0;
      if (rd_en) begin
        rd_data_d  = rd_word;
        rd_valid_d = 1'b1;
      end
    end
  end

  assign bypass_hit = (state_q == READY) && wr_en && (wr_addr == rd_addr);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lane_rdata;

    ram_lane #(
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk_i   (clk),
      .we_i    (lane_we[i]),
      .waddr_i (lane_waddr),
      .wdata_i (lane_wdata[i*LANE_W +: LANE_W]),
      .raddr_i (rd_addr),
      .rdata_o (lane_rdata)
    );

    // Write-first: an enabled lane written this edge returns the new data.
    assign rd_word[i*LANE_W +: LANE_W] =
      (bypass_hit && wr_be[i]) ? wr_data[i*LANE_W +: LANE_W] : lane_rdata;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sync_ram_2p.sv
// Directed bench for sync_ram_2p with two 8-bit lanes and 16 words.
module tb_sync_ram_2p;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 2;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = LANE_W * NUM_LANES;
  localparam int DEPTH     = 2**ADDR_W;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 wr_en = 1'b0;
  logic [ADDR_W-1:0]    wr_addr = '0;
  logic [DATA_W-1:0]    wr_data = '0;
  logic [NUM_LANES-1:0] wr_be = '0;
  logic                 rd_en = 1'b0;
  logic [ADDR_W-1:0]    rd_addr = '0;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_valid;
  logic                 clear_req = 1'b0;
  logic                 init_busy;

  int checks = 0;
  int errors = 0;

  sync_ram_2p #(
    .LANE_W         (LANE_W),
    .NUM_LANES      (NUM_LANES),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .clear_req (clear_req),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0; wr_be = '0;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [NUM_LANES-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  // Counts cycles until init_busy falls; bounded so a stuck sequencer still ends the run.
  task automatic count_busy(input string tag, output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (init_busy && n < 100) begin
      tick();
      n++;
      if (rd_valid) saw_valid = 1'b1;
    end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  task automatic read_all_zero(input string tag);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = ADDR_W'(i);
      tick();
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_data"}, 32'(rd_data), 32'd0);
    end
    rd_en = 1'b0;
    tick();
    chk({tag, "_valid_drop"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    int  n;
    bit  saw_valid;

    // Power-on reset with requests already pending during the clear.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd2;
    count_busy("init_len", n, saw_valid);
    chk("init_no_valid", 32'(saw_valid), 32'd0);
    idle();
    tick();
    read_all_zero("post_init");

    // Byte-lane merge.
    write(4'd3, 16'hABCD, 2'b11);
    write(4'd3, 16'h00EE, 2'b01);
    read("lane_merge", 4'd3, 16'hABEE);
    write(4'd3, 16'hFFFF, 2'b00);
    read("be_zero_noop", 4'd3, 16'hABEE);

    // Same-edge read/write, partial lanes: write-first on enabled lane only.
    write(4'd5, 16'h5678, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234; wr_be = 2'b10;
    read("rdw_bypass", 4'd5, 16'h1278);
    idle();
    read("rdw_commit", 4'd5, 16'h1278);

    // Different addresses on the same edge are independent.
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'hAAAA; wr_be = 2'b11;
    read("diff_addr_rd", 4'd5, 16'h1278);
    idle();
    read("diff_addr_wr", 4'd6, 16'hAAAA);
    tick();
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", 32'(rd_data), 32'hAAAA);

    // clear_req with a concurrent read of the last word.
    write(4'd15, 16'h0077, 2'b11);
    clear_req = 1'b1;
    read("clr_same_edge", 4'd15, 16'h0077);
    clear_req = 1'b0;
    chk("clr_busy_now", 32'(init_busy), 32'd1);
    count_busy("clr_len", n, saw_valid);
    read("clr_addr15", 4'd15, 16'h0000);
    read("clr_addr3", 4'd3, 16'h0000);

    // Reset in the middle of a clear sequence.
    write(4'd9, 16'h4242, 2'b11);
    clear_req = 1'b1;
    read("pre_rst_rd", 4'd9, 16'h4242);
    clear_req = 1'b0;
    repeat (7) tick();
    chk("mid_clr_busy", 32'(init_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_busy", 32'(init_busy), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy("rst_restart_len", n, saw_valid);
    tick();
    read_all_zero("post_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_ram_2p.md
Name: sync_ram_2p

Overview:
- Parametrised simple-dual-port RAM (one write port, one read port) on a single clock.
- Successor to the team's small 16x8 scratch RAM. Adds:
  - a synchronous, clocked write (no write-enable used as a clock)
  - a registered read with a valid flag
  - per-lane byte enables
  - write-first bypass
  - a hardware clear sequencer that zeroes the array after reset or on request
- Sits between the datapath/controller and local scratch storage.

Parameters:
- LANE_W, 8: bits per write lane.
- NUM_LANES, 1: lanes per word. DATA_W = LANE_W*NUM_LANES.
- ADDR_W, 4: address width. DEPTH = 2**ADDR_W words, so every address is valid.
- CLEAR_ON_RESET, 1: 1 = run the clear sequence after reset release; 0 = enter READY directly, with array contents undefined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  NUM_LANES  lane enables; bit i covers wr_data[i*LANE_W +: LANE_W].
- rd_en  in  1  read request this cycle.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse: rd_data was updated by the read accepted on the previous edge.
- clear_req  in  1  request a full-array clear (sampled only in READY).
- init_busy  out  1  high while the clear sequence runs; all requests are dropped while high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data=0, rd_valid=0, clr_ptr=0.
  - state=INIT and init_busy=1 if CLEAR_ON_RESET, else state=READY and init_busy=0.
  - The array itself is not reset.
- States: INIT, READY.
- INIT:
  - Each edge writes 0 to all lanes of mem[clr_ptr], then clr_ptr++.
  - On the edge that writes DEPTH-1, state goes to READY and init_busy goes to 0. init_busy is therefore high for exactly DEPTH cycles.
  - wr_en, rd_en and clear_req are ignored (not queued). rd_valid stays 0 and rd_data holds its value.
- READY, write:
  - On an edge with wr_en=1, for each lane i with wr_be[i]=1, mem[wr_addr] lane i <= wr_data lane i.
  - Lanes with wr_be[i]=0 are unchanged. wr_be=0 with wr_en=1 is a no-op.
- READY, read:
  - Latency 1. On an edge with rd_en=1, rd_data <= mem[rd_addr] and rd_valid <= 1.
  - On an edge with rd_en=0, rd_valid <= 0 and rd_data holds.
  - Back-to-back reads give a continuous rd_valid.
- Read-during-write, same address, same edge (write-first):
  - Lanes with wr_be=1 return wr_data.
  - Other lanes return the old contents.
  - Different addresses: fully independent.
- clear_req in READY:
  - Any write and read presented on that same edge complete normally.
  - Next state is INIT with clr_ptr=0 and init_busy=1 from the following cycle.
  - The clear then takes DEPTH cycles. This holds regardless of CLEAR_ON_RESET.
- Reset asserted mid-INIT or mid-operation: everything returns to reset values immediately; the clear sequence restarts from address 0 after release.
- clr_ptr is ADDR_W bits wide and wraps naturally. The transition is decoded from clr_ptr == DEPTH-1, not from overflow.

Decomposition:
- Shared package sync_ram_pkg:
  - state enum {INIT, READY}
  - function computing DATA_W from LANE_W/NUM_LANES
- One natural sub-module: ram_lane, one LANE_W x DEPTH array with its own write enable, instantiated NUM_LANES times via generate.
- The top level owns the FSM, the clear pointer, the write-first bypass mux and the read register.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> init_busy high exactly 16 cycles; then read all addresses -> every rd_data=0, rd_valid pulses once per read.
- NUM_LANES=2, LANE_W=8: write 0xABCD to addr 3 with wr_be=2'b11, then 0x00EE with wr_be=2'b01, then read addr 3 -> rd_data=0xABEE one cycle after rd_en.
- Same edge: wr_en, addr 5, data 0x1234, be=2'b10, old mem[5]=0x5678; rd_en, addr 5 -> rd_data=0x1278.
- Assert wr_en and rd_en during init_busy -> no array change (verify with a post-init read = 0), rd_valid stays 0.
- Write 0x77 to addr 15, then assert clear_req together with a read of addr 15 -> rd_data=0x77; init_busy=1 for the next 16 cycles; then read addr 15 -> 0x00.
- Pull rst_n low at clear step 7, release -> init_busy high a full 16 cycles from release, all addresses read 0 afterwards.
